obuf_drain_reader: RTL
======================

Name: obuf_drain_reader

Overview:
Reads accumulated results out of the 16-bank output buffer (O buf) after the SIMD bias/ReLU stage has written them, and streams them as 32-bit words over a valid/ready interface toward the output BRAM/host path. It is the read side of the O buf write path. It drives the buffer's bank-select and read-address inputs, absorbs the fixed RAM read latency with a 2-entry skid FIFO, and emits words in row-major order (row r, then columns 0..num_cols-1). It sits between the O buf and the data_in_o_bram consumer, in place of hand-driven o_ram_idx/o_read_addr sequencing.

Parameters:
- ARRAY_M, 16: number of O buf banks (output columns).
- PE_OUT_WIDTH, 32: word width of each O buf bank.
- RAM_SIZE, 1024: entries per bank.
- ADDR_WIDTH, $clog2(RAM_SIZE): O buf address width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request to begin a drain; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  O buf address of row 0; latched on an accepted start.
- num_rows  input  $clog2(ARRAY_M)+1  rows to drain (0..ARRAY_M); latched on an accepted start.
- num_cols  input  $clog2(ARRAY_M)+1  banks per row (0..ARRAY_M); latched on an accepted start.
- busy  output  1  high from an accepted start until the done cycle, inclusive.
- done  output  1  one-cycle pulse when the drain completes.
- o_ram_idx  output  $clog2(ARRAY_M)  bank select for the read.
- o_read_addr  output  ADDR_WIDTH  read address.
- o_rd_en  output  1  read strobe; data is valid on o_rd_data exactly 1 cycle later.
- o_rd_data  input  PE_OUT_WIDTH  read data from the selected bank.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer ready.
- m_data  output  PE_OUT_WIDTH  output word.
- m_last  output  1  high on the final word of the drain.

Behaviour:
- Reset (reset==0 at a clk edge) clears everything: busy=0, done=0, o_rd_en=0, o_ram_idx=0, o_read_addr=0, m_valid=0, m_data=0, m_last=0, FIFO empty, state=IDLE.
- Reset asserted mid-drain aborts the drain. In-flight read data is discarded and no done pulse is produced.
- States:
  - IDLE: waits for start.
  - ISSUE: issues reads.
  - FLUSH: all reads issued; waits for the FIFO to empty.
  - DONE: one cycle; done=1; then returns to IDLE.
- Accepted start: latch parameters and clamp num_rows and num_cols to ARRAY_M.
  - If either clamped count is 0, go straight to DONE (done rises the cycle after start), with no reads and no beats.
  - Otherwise go to ISSUE.
- start in any state other than IDLE is ignored.
- Read order: for r in 0..rows-1, for c in 0..cols-1, o_ram_idx=c and o_read_addr=(base_addr+r) mod RAM_SIZE.
  - The address wraps from RAM_SIZE-1 to 0.
- Credit rule: o_rd_en=1 in ISSUE only when (FIFO count + reads in flight) < 2. The 2-entry FIFO therefore never overflows.
  - Reads in flight is 0 or 1.
  - Credit counting includes the pop happening in the same cycle.
- Read data is pushed into the FIFO on the cycle after o_rd_en, together with a last flag. The flag is set for the final (r,c) pair.
- The FIFO head drives m_data and m_last. m_valid = FIFO not empty.
- A beat transfers when m_valid && m_ready.
- While m_valid && !m_ready, m_data and m_last are held stable.
- Full throughput: with m_ready held at 1, one beat per cycle after the first. First m_valid comes 2 cycles after the first o_rd_en. Push and pop in the same cycle are both allowed.
- After the last read issues, go to FLUSH. When the last-flagged beat transfers, go to DONE. done=1 for exactly one cycle, busy drops the following cycle, and the state returns to IDLE.
- Total beats per drain = rows*cols. m_last is high on exactly one beat.

Decomposition:
- Shared package holds:
  - Default ARRAY_M, PE_OUT_WIDTH, RAM_SIZE, ADDR_WIDTH.
  - The state encoding (IDLE/ISSUE/FLUSH/DONE) as localparams.
  - The read latency constant RD_LAT=1.
- One sub-module: obuf_skid_fifo.
  - 2 entries, width PE_OUT_WIDTH+1 (data plus last flag).
  - Ports: push/pop/count/full/empty.
  - Simultaneous push and pop keeps the count unchanged.

Test Plan:
- Reset with start=1 and m_ready=1 -> all outputs 0; no o_rd_en for 5 cycles.
- base_addr=0, rows=10, cols=10, bank c address r preloaded with r*16+c, m_ready=1 -> 100 beats with values 0x00..0x09, 0x10..0x19, ...; m_last on 0x99; done once; 1 beat/cycle.
- Same drain with m_ready toggling 1,0,0,1 -> identical sequence; m_data stable during stalls; at most 2 reads outstanding; no beat lost or duplicated.
- base_addr=1022, rows=4, cols=2 -> addresses read in order 1022, 1023, 0, 1 (each for banks 0,1); 8 beats.
- rows=0, cols=5 -> done the cycle after start, zero reads, zero beats. rows=20, cols=16 -> clamped to 16x16 = 256 beats.
- Reset pulsed low mid-drain (after 7 beats), then a new start -> first beat of the new drain is row 0 col 0; no stale data; no done from the aborted run.

Source files
------------

// File: rtl/obuf_drain_reader_pkg.sv
// obuf_drain_reader_pkg: shared defaults, state encoding and read latency for the O buf drain reader.
package obuf_drain_reader_pkg;
   localparam int ARRAY_M      = 16;
   localparam int PE_OUT_WIDTH = 32;
   localparam int RAM_SIZE     = 1024;
   localparam int ADDR_WIDTH   = $clog2(RAM_SIZE);
   localparam int RD_LAT       = 1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      FLUSH = ST_FLUSH,
      DONE  = ST_DONE
   } state_t;
endpackage

// File: rtl/obuf_drain_reader_skid_fifo.sv
// obuf_skid_fifo: 2-entry FIFO absorbing O buf read latency; push and pop may coincide, even when full.
module obuf_skid_fifo #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_q, rd_d, wr_q, wr_d, do_push, do_pop;
   logic [1:0]   cnt_q, cnt_d;

   always_comb begin
      empty   = cnt_q == 2'd0;
      full    = cnt_q == 2'd2;
      count   = cnt_q;
      head    = mem_q[rd_q];
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      if (do_push) mem_d[wr_q] = push_data;
      wr_d    = do_push ? !wr_q : wr_q;
      rd_d    = do_pop ? !rd_q : rd_q;
      cnt_d   = 2'(cnt_q + 2'(do_push) - 2'(do_pop));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q <= '{default: '0};
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/obuf_drain_reader.sv
// obuf_drain_reader: drains the 16-bank O buf row-major into a 32-bit valid/ready stream.
module obuf_drain_reader #(
   parameter int ARRAY_M      = obuf_drain_reader_pkg::ARRAY_M,
   parameter int PE_OUT_WIDTH = obuf_drain_reader_pkg::PE_OUT_WIDTH,
   parameter int RAM_SIZE     = obuf_drain_reader_pkg::RAM_SIZE,
   parameter int ADDR_WIDTH   = $clog2(RAM_SIZE)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
   input  logic [$clog2(ARRAY_M):0]      num_rows,
   input  logic [$clog2(ARRAY_M):0]      num_cols,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(ARRAY_M)-1:0]    o_ram_idx,
   output logic [ADDR_WIDTH-1:0]         o_read_addr,
   output logic                          o_rd_en,
   input  logic [PE_OUT_WIDTH-1:0]       o_rd_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [PE_OUT_WIDTH-1:0]       m_data,
   output logic                          m_last
);
   import obuf_drain_reader_pkg::*;
   localparam int CW = $clog2(ARRAY_M) + 1;
   localparam int IW = $clog2(ARRAY_M);

   state_t                state_q, state_d;
   logic [CW-1:0]         rows_q, rows_d, cols_q, cols_d, row_q, row_d, rows_c, cols_c;
   logic [IW-1:0]         idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [RD_LAT-1:0]     pend_q, pend_d, plast_q, plast_d;
   logic                  last_rc, pop, rd_en, fifo_full, fifo_empty;
   logic [1:0]            fifo_count;
   logic [PE_OUT_WIDTH:0] fifo_head;

   obuf_skid_fifo #(.W(PE_OUT_WIDTH + 1)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pend_q[RD_LAT-1]),
      .push_data ({plast_q[RD_LAT-1], o_rd_data}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      rows_c  = num_rows > CW'(ARRAY_M) ? CW'(ARRAY_M) : num_rows;
      cols_c  = num_cols > CW'(ARRAY_M) ? CW'(ARRAY_M) : num_cols;
      last_rc = (row_q == rows_q - 1'b1) && ({1'b0, idx_q} == cols_q - 1'b1);
      m_valid = !fifo_empty;
      m_data  = fifo_empty ? '0 : fifo_head[PE_OUT_WIDTH-1:0];
      m_last  = !fifo_empty && fifo_head[PE_OUT_WIDTH];
      pop     = m_valid && m_ready;
      // Credit covers FIFO occupancy after this cycle's pop plus reads still in the RAM pipe.
      rd_en   = (state_q == ISSUE) &&
                (int'(fifo_count) - int'(pop) + $countones(pend_q) < 2);
      state_d = state_q;
      rows_d  = rows_q;
      cols_d  = cols_q;
      row_d   = row_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: if (start) begin
            rows_d  = rows_c;
            cols_d  = cols_c;
            row_d   = '0;
            idx_d   = '0;
            addr_d  = base_addr;
            state_d = (rows_c == '0 || cols_c == '0) ? DONE : ISSUE;
         end
         ISSUE: if (rd_en) begin
            if (last_rc) state_d = FLUSH;
            else if ({1'b0, idx_q} == cols_q - 1'b1) begin
               idx_d  = '0;
               row_d  = row_q + 1'b1;
               addr_d = addr_q == ADDR_WIDTH'(RAM_SIZE - 1) ? '0 : addr_q + 1'b1;
            end else idx_d = idx_q + 1'b1;
         end
         FLUSH: if (pop && fifo_head[PE_OUT_WIDTH]) state_d = DONE;
         DONE: state_d = IDLE;
      endcase
      busy_d     = state_d != IDLE;
      done_d     = state_d == DONE;
      pend_d     = pend_q;
      plast_d    = plast_q;
      pend_d[0]  = rd_en;
      plast_d[0] = rd_en && last_rc;
      for (int i = 1; i < RD_LAT; i++) begin
         pend_d[i]  = pend_q[i-1];
         plast_d[i] = plast_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         rows_q  <= '0;
         cols_q  <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= '0;
         plast_q <= '0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
         row_q   <= row_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         plast_q <= plast_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign o_rd_en     = rd_en;
   assign o_ram_idx   = idx_q;
   assign o_read_addr = addr_q;
endmodule
